// File: rtl/div_iterative_pkg.sv
// Shared ALU constants and the divider FSM state encoding.
package div_iterative_pkg;

   // One quotient bit is resolved per iteration.
   localparam int DIV_ITERS = 32;

   // Most negative 32-bit value; its magnitude only fits as unsigned.
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/csa_adder.sv
// Carry-select adder: each BLK-bit block precomputes its sum for both
// incoming carries and the carry chain only drives the block muxes.
// W must be a multiple of BLK.
module csa_adder #(
   parameter int W   = 32,
   parameter int BLK = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int NB = W / BLK;

   logic [NB:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < NB; i++) begin : g_blk
      logic [BLK:0] s0;
      logic [BLK:0] s1;

      assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
      assign s1 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]} + (BLK+1)'(1);

      assign sum[i*BLK +: BLK] = carry[i] ? s1[BLK-1:0] : s0[BLK-1:0];
      assign carry[i+1]        = carry[i] ? s1[BLK]     : s0[BLK];
   end

   assign cout = carry[NB];

endmodule

// File: rtl/div_iterative_div_step.sv
// One restoring shift-subtract step of the unsigned divider. Purely
// combinational; the subtract goes through the carry-select adder.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic [W-1:0] quo_in,
   input  logic [W-1:0] dvs,
   output logic [W-1:0] rem_out,
   output logic [W-1:0] quo_out
);

   // Shifted partial remainder is W+1 bits: old remainder plus the
   // quotient MSB that falls out of the {rem, quo} shift.
   logic [W:0]   rem_sh;
   logic [W-1:0] trial;
   logic         no_borrow;
   logic         fits;

   assign rem_sh = {rem_in, quo_in[W-1]};

   // trial = rem_sh[W-1:0] - dvs as a + ~b + 1; the carry out is the
   // "no borrow" indication for the low W bits.
   csa_adder #(.W(W)) u_sub (
      .a    (rem_sh[W-1:0]),
      .b    (~dvs),
      .cin  (1'b1),
      .sum  (trial),
      .cout (no_borrow)
   );

   // With the extra top bit set the remainder is >= 2^W > dvs, so the
   // subtract always succeeds; the true difference still fits in W bits
   // because the previous remainder was below dvs.
   assign fits = rem_sh[W] | no_borrow;

   assign rem_out = fits ? trial : rem_sh[W-1:0];
   assign quo_out = {quo_in[W-2:0], fits};

endmodule

// File: rtl/div_iterative.sv
// Multi-cycle signed 32-bit divider: magnitudes on the start edge,
// DIV_ITERS restoring steps, then a sign/exception fix-up cycle that
// pulses result_rdy. Quotient truncates toward zero.
module div_iterative
   import div_iterative_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             result_rdy
);

   localparam int               CNT_W    = $clog2(DIV_ITERS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   div_state_t       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_sign;
   logic             zero_flag;
   logic             ovf_flag;

   logic [WIDTH-1:0] abs_dividend;
   logic [WIDTH-1:0] abs_divisor;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] neg_quo;
   logic             neg_cout;

   // Magnitudes; INT_MIN maps onto itself, read as unsigned 2^(W-1).
   assign abs_dividend = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
   assign abs_divisor  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

   div_step #(.W(WIDTH)) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .dvs     (dvs),
      .rem_out (step_rem),
      .quo_out (step_quo)
   );

   // Two's complement negation of the quotient through the shared adder.
   // Its carry out is set only for a zero quotient, whose negation is zero.
   csa_adder #(.W(WIDTH)) u_neg (
      .a    (~quo),
      .b    ({WIDTH{1'b0}}),
      .cin  (1'b1),
      .sum  (neg_quo),
      .cout (neg_cout)
   );

   // Control FSM with the iteration datapath and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         rem        <= '0;
         quo        <= '0;
         dvs        <= '0;
         neg_sign   <= 1'b0;
         zero_flag  <= 1'b0;
         ovf_flag   <= 1'b0;
         result     <= '0;
         exception  <= 1'b0;
         result_rdy <= 1'b0;
      end else begin
         result_rdy <= 1'b0;
         case (state)
            IDLE: begin
               if (ctrl_div) begin
                  rem       <= '0;
                  quo       <= abs_dividend;
                  dvs       <= abs_divisor;
                  neg_sign  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  zero_flag <= (divisor == '0);
                  ovf_flag  <= (dividend == MIN_VAL) && (divisor == ALL_ONES);
                  count     <= '0;
                  state     <= ITER;
               end
            end
            ITER: begin
               rem   <= step_rem;
               quo   <= step_quo;
               count <= count + CNT_W'(1);
               if (count == LAST_CNT) begin
                  state <= FIX;
               end
            end
            FIX: begin
               if (zero_flag) begin
                  result    <= '0;
                  exception <= 1'b1;
               end else if (ovf_flag) begin
                  result    <= MIN_VAL;
                  exception <= 1'b1;
               end else begin
                  result    <= (neg_sign && !neg_cout) ? neg_quo : quo;
                  exception <= 1'b0;
               end
               result_rdy <= 1'b1;
               count      <= '0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_iterative.sv
// Directed and random checks of div_iterative against an arithmetic
// reference model of signed truncating division.
module tb_div_iterative;

   logic        clock;
   logic        reset;
   logic        ctrl_div;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] result;
   logic        exception;
   logic        result_rdy;

   int          n_tests;
   int          n_fail;
   logic [31:0] last_res;
   logic        last_exc;

   div_iterative #(.WIDTH(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .ctrl_div   (ctrl_div),
      .dividend   (dividend),
      .divisor    (divisor),
      .result     (result),
      .exception  (exception),
      .result_rdy (result_rdy)
   );

   // Clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference: signed quotient truncated toward zero; a zero divisor or a
   // quotient that does not fit in 32 bits is an exception. {exc, quotient}.
   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) return {1'b1, 32'h0000_0000};
      q = sa / sb;
      if (q > 64'sd2147483647 || q < -64'sd2147483648) return {1'b1, 32'h8000_0000};
      return {1'b0, q[31:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Start one divide and wait for completion; optionally pulse ctrl_div
   // again poke_at edges after the start. Returns in the result_rdy cycle.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input string tag);
      logic [32:0] expv;
      int          lat;
      bit          seen;
      expv = ref_div(a, b);
      @(negedge clock);
      dividend = a;
      divisor  = b;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clock);
         #1;
         lat++;
         ctrl_div = 1'b0;
         if (result_rdy === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (lat == 20) begin
               check({tag, "_hold_res"}, 64'(result), 64'(last_res));
               check({tag, "_hold_exc"}, 64'(exception), 64'(last_exc));
            end
            if (poke_at != 0 && lat == poke_at) begin
               ctrl_div = 1'b1;
               dividend = 32'd1;
               divisor  = 32'd1;
            end
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'd33);
      check({tag, "_result"}, 64'(result), 64'(expv[31:0]));
      check({tag, "_exception"}, 64'(exception), 64'(expv[32]));
      last_res = expv[31:0];
      last_exc = expv[32];
   endtask

   // Count result_rdy pulses over n cycles; none are expected.
   task automatic quiet(input int n, input string tag);
      int pulses;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (result_rdy !== 1'b0) pulses++;
      end
      check({tag, "_no_rdy"}, 64'(pulses), 64'd0);
   endtask

   // Start a divide and hit reset asynchronously at_edge edges later.
   task automatic run_abort(input logic [31:0] a, input logic [31:0] b,
                            input int at_edge, input string tag);
      @(negedge clock);
      dividend = a;
      divisor  = b;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1;
      ctrl_div = 1'b0;
      repeat (at_edge) @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      check({tag, "_result"}, 64'(result), 64'd0);
      check({tag, "_exception"}, 64'(exception), 64'd0);
      check({tag, "_rdy"}, 64'(result_rdy), 64'd0);
      @(negedge clock);
      reset    = 1'b0;
      last_res = 32'd0;
      last_exc = 1'b0;
      quiet(40, tag);
   endtask

   // Stimulus sequence
   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      n_tests  = 0;
      n_fail   = 0;
      last_res = 32'd0;
      last_exc = 1'b0;
      reset    = 1'b1;
      ctrl_div = 1'b0;
      dividend = 32'd0;
      divisor  = 32'd0;

      repeat (3) @(posedge clock);
      #1;
      check("reset_result", 64'(result), 64'd0);
      check("reset_exception", 64'(exception), 64'd0);
      check("reset_rdy", 64'(result_rdy), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      run_div(32'd100, 32'd7, 0, "pos_pos");
      quiet(2, "pulse_width");
      run_div(32'hFFFF_FF9C, 32'd7, 0, "neg_pos");
      run_div(32'd100, 32'hFFFF_FFF9, 0, "pos_neg");
      run_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, "neg_neg");
      run_div(32'd7, 32'd100, 0, "small_big");
      run_div(32'd5, 32'd0, 0, "div_zero");
      run_div(32'd9, 32'd3, 0, "after_zero");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, "overflow");
      run_div(32'h8000_0000, 32'd2, 0, "min_by_2");

      run_div(32'd1000, 32'd10, 10, "ignore_restart");
      quiet(40, "ignore_restart");

      run_div(32'd42, 32'd6, 0, "b2b_first");
      run_div(32'd12345, 32'd5, 0, "b2b_second");
      quiet(2, "b2b");

      run_abort(32'd1000, 32'd3, 15, "abort");
      run_div(32'd81, 32'd9, 0, "after_abort");

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(1, 100));
            2: rb = -32'($urandom_range(1, 100));
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
         run_div(ra, rb, 0, $sformatf("rand%0d", i));
      end

      quiet(3, "tail");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_iterative.md
# div_iterative

Multi-cycle 32-bit signed integer divider for the processor ALU. It is the inverse companion of the single-cycle carry-select adder path: it reuses that adder as a subtractor in a restoring shift-subtract loop. Start is a one-cycle `ctrl_div` pulse. The block computes quotient = dividend / divisor, truncated toward zero, flags illegal cases, and pulses `result_rdy` when done. The ALU control stalls on `result_rdy`.

## Interface
Parameters:
- `WIDTH`, default 32. Operand and quotient width. Only 32 is verified.

Ports:
- `clock`: in, 1 bit. Single clock, rising edge.
- `reset`: in, 1 bit. Asynchronous, active-high.
- `ctrl_div`: in, 1 bit. Start pulse. Sampled on the rising edge.
- `dividend`: in, 32 bits. Two's complement. Captured on the start edge only.
- `divisor`: in, 32 bits. Two's complement. Captured on the start edge only.
- `result`: out, 32 bits. Quotient. Held until the next completion.
- `exception`: out, 1 bit. Divide-by-zero or overflow. Valid while `result_rdy` is high; held with `result`.
- `result_rdy`: out, 1 bit. One-cycle completion pulse.

## Operation
- States:
  - IDLE → ITER on `ctrl_div`=1.
  - ITER runs exactly 32 cycles, counted by a 5-bit counter 0..31, then goes to FIX.
  - FIX → IDLE.
- Start edge actions:
  - Capture `|dividend|` and `|divisor|`.
  - Capture sign = `dividend[31]` ^ `divisor[31]`.
  - Capture zero flag = (divisor == 0) and overflow flag = (dividend == 0x80000000 && divisor == 0xFFFFFFFF).
  - Clear the 33-bit partial remainder. Load the quotient register with `|dividend|`.
- Absolute value of 0x80000000 is 0x80000000 taken as unsigned. The datapath is unsigned 32-bit internally.
- Each ITER cycle:
  - Shift {remainder, quotient} left by 1.
  - trial = remainder − |divisor|, computed as adder(remainder, ~|divisor|, cin=1).
  - If trial ≥ 0: remainder ← trial and quotient LSB ← 1. Otherwise restore and set LSB ← 0.
- FIX cycle:
  - If the zero flag is set: `result`=0, `exception`=1.
  - Else if the overflow flag is set: `result`=0x80000000, `exception`=1.
  - Else: `result` = sign ? −quotient : quotient, and `exception`=0.
  - Assert `result_rdy`.
- The remainder is discarded and is not an output.
- `ctrl_div` while in ITER or FIX is ignored. No restart, no queueing.
- `ctrl_div` asserted in the same cycle that `result_rdy` is high is accepted, because the FSM is in IDLE by then.
- Reset at any time, including mid-ITER:
  - Abandons the operation and returns the FSM to IDLE.
  - `result`=0, `exception`=0, `result_rdy`=0, counter=0.
  - No `result_rdy` is issued for the abandoned operation.

## Timing
- Reset values: `result` 0x00000000, `exception` 0, `result_rdy` 0.
- Fixed latency, independent of operand values (zero and overflow cases included):
  - Start edge E0; ITER edges E1..E32; FIX edge E33.
  - `result_rdy`=1 for exactly the one cycle following E33.
- `result` and `exception` change only at E33. They are stable from then until the next E33 or reset.
- Throughput: one divide per 34 cycles at most.
- Critical path: one 32-bit subtract plus a 2:1 mux per cycle.

## Structure
- Shared ALU package holds:
  - `DIV_ITERS`=32
  - FSM state encoding: IDLE=2'd0, ITER=2'd1, FIX=2'd2
  - `INT_MIN`=32'h80000000
- One natural sub-module: `div_step`. It is combinational: one shift-subtract-restore step, instantiating the team's carry-select adder as the subtractor. Top level holds the FSM, counter, sign logic and output registers.
- The negation in FIX reuses the adder: ~q + 1.

## Test plan
- 100 / 7 → `result`=14, `exception`=0, `result_rdy` high exactly 33 edges after start, for 1 cycle.
- −100 / 7 → 0xFFFFFFF2 (−14). 100 / −7 → −14. −100 / −7 → 14. 7 / 100 → 0.
- 5 / 0 → `result`=0, `exception`=1, same latency. Next divide 9 / 3 → 3 with `exception`=0.
- 0x80000000 / 0xFFFFFFFF → `result`=0x80000000, `exception`=1. 0x80000000 / 2 → 0xC0000000, `exception`=0.
- Start 1000 / 10, pulse `ctrl_div` again at cycle 10 with 1 / 1 → only 100 is returned, exactly one `result_rdy`. Start issued in the `result_rdy` cycle is accepted and completes 33 edges later.
- Assert `reset` asynchronously at cycle 15 of a divide → outputs 0 immediately, no `result_rdy`. A new 81 / 9 afterwards returns 9.
